// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register: captures decoded control and operands for EXE,
// with stall (freeze), branch squash (flush) and a saturating bubble counter.
module id_exe_reg #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic              imm_in,
  input  logic [3:0]        EXE_CMD_in,
  input  logic [DATA_W-1:0] PC_in,
  input  logic [DATA_W-1:0] Val_Rn_in,
  input  logic [DATA_W-1:0] Val_Rm_in,
  input  logic [11:0]       Shift_operand_in,
  input  logic [23:0]       Signed_imm_24_in,
  input  logic [3:0]        Dest_in,
  input  logic [3:0]        src1_in,
  input  logic [3:0]        src2_in,
  input  logic [3:0]        SR_in,
  input  logic              valid_in,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic              MEM_W_EN_out,
  output logic              B_out,
  output logic              S_out,
  output logic              imm_out,
  output logic [3:0]        EXE_CMD_out,
  output logic [DATA_W-1:0] PC_out,
  output logic [DATA_W-1:0] Val_Rn_out,
  output logic [DATA_W-1:0] Val_Rm_out,
  output logic [11:0]       Shift_operand_out,
  output logic [23:0]       Signed_imm_24_out,
  output logic [3:0]        Dest_out,
  output logic [3:0]        src1_out,
  output logic [3:0]        src2_out,
  output logic [3:0]        SR_out,
  output logic              valid_out,
  output logic              Cin,
  output logic [15:0]       bubble_cnt
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic load;
  logic bubble;

  assign load   = !flush && !freeze;
  // A bubble enters EXE on a flush or on a load of an empty ID slot.
  assign bubble = flush || (load && !valid_in);

  assign Cin = SR_out[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      WB_EN_out         <= 1'b0;
      MEM_R_EN_out      <= 1'b0;
      MEM_W_EN_out      <= 1'b0;
      B_out             <= 1'b0;
      S_out             <= 1'b0;
      imm_out           <= 1'b0;
      EXE_CMD_out       <= '0;
      PC_out            <= '0;
      Val_Rn_out        <= '0;
      Val_Rm_out        <= '0;
      Shift_operand_out <= '0;
      Signed_imm_24_out <= '0;
      Dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      SR_out            <= '0;
      valid_out         <= 1'b0;
    end else if (flush) begin
      WB_EN_out         <= 1'b0;
      MEM_R_EN_out      <= 1'b0;
      MEM_W_EN_out      <= 1'b0;
      B_out             <= 1'b0;
      S_out             <= 1'b0;
      imm_out           <= 1'b0;
      EXE_CMD_out       <= '0;
      PC_out            <= '0;
      Val_Rn_out        <= '0;
      Val_Rm_out        <= '0;
      Shift_operand_out <= '0;
      Signed_imm_24_out <= '0;
      Dest_out          <= '0;
      src1_out          <= '0;
      src2_out          <= '0;
      SR_out            <= '0;
      valid_out         <= 1'b0;
    end else if (!freeze) begin
      // Side-effecting controls are gated so an empty slot cannot write anything.
      WB_EN_out         <= WB_EN_in    && valid_in;
      MEM_R_EN_out      <= MEM_R_EN_in && valid_in;
      MEM_W_EN_out      <= MEM_W_EN_in && valid_in;
      B_out             <= B_in        && valid_in;
      S_out             <= S_in        && valid_in;
      imm_out           <= imm_in;
      EXE_CMD_out       <= EXE_CMD_in;
      PC_out            <= PC_in;
      Val_Rn_out        <= Val_Rn_in;
      Val_Rm_out        <= Val_Rm_in;
      Shift_operand_out <= Shift_operand_in;
      Signed_imm_24_out <= Signed_imm_24_in;
      Dest_out          <= Dest_in;
      src1_out          <= src1_in;
      src2_out          <= src2_in;
      SR_out            <= SR_in;
      valid_out         <= valid_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != CNT_MAX)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of PC, Val_Rn and Val_Rm.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 freeze  input  1  hazard stall; hold all registered outputs.
REQ-005 flush  input  1  branch taken; replace captured instruction with a bubble.
REQ-006 WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, B_in, S_in, imm_in  input  1 each  decoded control bits from ID.
REQ-007 EXE_CMD_in  input  4  ALU operation code.
REQ-008 PC_in, Val_Rn_in, Val_Rm_in  input  DATA_W each  PC+4 and register-file read values.
REQ-009 Shift_operand_in  input  12; Signed_imm_24_in  input  24; Dest_in, src1_in, src2_in  input  4 each.
REQ-010 SR_in  input  4  status register {N,Z,C,V} at decode time.
REQ-011 valid_in  input  1  ID stage holds a real instruction.
REQ-012 Outputs: each *_in above has a registered *_out of identical width (including valid_out).
REQ-013 Cin  output  1  ALU carry-in, equal to SR_out[1] (C bit), combinational from the register.
REQ-014 bubble_cnt  output  16  saturating count of bubbles issued to EXE.

Function
REQ-015 Per rising edge, exactly one action, in priority order: flush, freeze, load.
REQ-016 Flush: WB_EN, MEM_R_EN, MEM_W_EN, B, S, valid_out cleared to 0; EXE_CMD_out cleared to 0000 (ALU default -> result 0); data fields cleared to 0.
REQ-017 Flush wins over a simultaneous freeze; the frozen instruction is discarded.
REQ-018 Freeze (flush=0): every output keeps its previous value, bubble_cnt unchanged.
REQ-019 Load (flush=0, freeze=0): every *_out takes its *_in value; latency exactly one cycle.
REQ-020 Load with valid_in=0: control bits WB_EN, MEM_R_EN, MEM_W_EN, B, S forced to 0 regardless of inputs; data fields still captured.
REQ-021 bubble_cnt increments by 1 on each edge where a flush occurs or a load occurs with valid_in=0.
REQ-022 bubble_cnt saturates at 16'hFFFF; no wrap to 0.
REQ-023 Freeze asserted across multiple cycles holds indefinitely; first edge after freeze drops loads current inputs.
REQ-024 No combinational path from any *_in to any output; Cin depends only on SR_out.
REQ-025 Block contains no handshake back-pressure; freeze/flush generation is the hazard and branch units' responsibility.

Reset
REQ-026 rst=1 immediately (without waiting for clk) clears every output, including valid_out, Cin and bubble_cnt, to 0.
REQ-027 rst asserted mid-freeze or coincident with flush: reset dominates; outputs 0 while rst=1.
REQ-028 First rising edge after rst deasserts performs a normal flush/freeze/load decision.

Verification
REQ-029 Load: valid_in=1, EXE_CMD_in=0010, Val_Rn_in=5, Val_Rm_in=7, WB_EN_in=1, SR_in=0010 -> after one edge EXE_CMD_out=0010, Val_Rn_out=5, Val_Rm_out=7, WB_EN_out=1, Cin=1, bubble_cnt=0.
REQ-030 Freeze: load PC_in=0x10, then freeze=1 for 3 cycles with PC_in=0x14 -> PC_out stays 0x10 for 3 edges, becomes 0x14 on first edge with freeze=0.
REQ-031 Flush vs freeze: valid instruction with MEM_W_EN_in=1, freeze=1 and flush=1 same edge -> MEM_W_EN_out=0, valid_out=0, EXE_CMD_out=0000, bubble_cnt increments by 1.
REQ-032 Invalid load: valid_in=0, WB_EN_in=1, S_in=1 -> WB_EN_out=0, S_out=0, bubble_cnt +1.
REQ-033 Async reset: rst pulsed between clock edges while outputs non-zero -> all outputs 0 before next edge; bubble_cnt=0.
REQ-034 Saturation: force 65,536 consecutive flushes -> bubble_cnt reaches 0xFFFF and remains 0xFFFF.
